// File: rtl/mcash_xbar_pkg.sv
// mcash_xbar_pkg: shared widths, channel constants and the return packet type of the bank->xbar return path
package mcash_xbar_pkg;
  localparam int CH_W = 2;
  localparam int ROB_W = 3;
  localparam int DATA_W = 128;
  localparam int NUM_CH = 3;
  localparam int NUM_BANK = 4;
  localparam logic [CH_W-1:0] CH_ID_ILLEGAL = 2'b11;
  typedef struct packed {
    logic [CH_W-1:0] ch_id;
    logic [ROB_W-1:0] rob_num;
    logic [DATA_W-1:0] data;
  } rtn_pkt_t;
endpackage

// File: rtl/bank_sc_rtn_tx_if.sv
// bank_sc_rtn_tx_if: response-in (rsp_*) and cross-bar-out (sc_xbar_*) handshakes; slave = transmitter, master = its environment
interface bank_sc_rtn_tx_if #(
  parameter int DATA_W = mcash_xbar_pkg::DATA_W,
  parameter int CH_W = mcash_xbar_pkg::CH_W,
  parameter int ROB_W = mcash_xbar_pkg::ROB_W
);
  logic rsp_valid_i;
  logic rsp_ready_o;
  logic [CH_W-1:0] rsp_ch_id_i;
  logic [ROB_W-1:0] rsp_rob_num_i;
  logic [DATA_W-1:0] rsp_data_i;
  logic sc_xbar_valid_o;
  logic sc_xbar_allowIn_i;
  logic [CH_W-1:0] sc_xbar_ch_id_o;
  logic [ROB_W-1:0] sc_xbar_rob_num_o;
  logic [DATA_W-1:0] sc_xbar_data_o;
  modport slave (
    input rsp_valid_i, rsp_ch_id_i, rsp_rob_num_i, rsp_data_i, sc_xbar_allowIn_i,
    output rsp_ready_o, sc_xbar_valid_o, sc_xbar_ch_id_o, sc_xbar_rob_num_o, sc_xbar_data_o
  );
  modport master (
    output rsp_valid_i, rsp_ch_id_i, rsp_rob_num_i, rsp_data_i, sc_xbar_allowIn_i,
    input rsp_ready_o, sc_xbar_valid_o, sc_xbar_ch_id_o, sc_xbar_rob_num_o, sc_xbar_data_o
  );
endinterface

// File: rtl/mcash_sync_fifo.sv
// mcash_sync_fifo: synchronous FIFO (clk, rst, push/din in, pop in, dout = head, full/empty/count out); storage not reset
module mcash_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  // extra MSB on each pointer tells full from empty when the index bits match
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/bank_sc_rtn_tx.sv
// bank_sc_rtn_tx: queues tagged bank read responses and drives them to the cross-bar ROB; clk_i/rst_i, bus (slave), occupancy_o, ch_err_o
module bank_sc_rtn_tx #(
  parameter int DEPTH = 4,
  parameter int DATA_W = mcash_xbar_pkg::DATA_W,
  parameter int CH_W = mcash_xbar_pkg::CH_W,
  parameter int ROB_W = mcash_xbar_pkg::ROB_W
) (
  input  logic clk_i,
  input  logic rst_i,
  bank_sc_rtn_tx_if.slave bus,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic ch_err_o
);
  localparam int W = CH_W + ROB_W + DATA_W;
  logic full, empty, push, ch_ok;
  logic [W-1:0] head;
  // ready is pure state (plus reset) so there is no combinational in->out path
  assign bus.rsp_ready_o = !full && !rst_i;
  assign push = bus.rsp_valid_i && bus.rsp_ready_o;
  assign ch_ok = bus.rsp_ch_id_i != CH_W'(mcash_xbar_pkg::CH_ID_ILLEGAL);
  assign bus.sc_xbar_valid_o = !empty;
  assign {bus.sc_xbar_ch_id_o, bus.sc_xbar_rob_num_o, bus.sc_xbar_data_o} = empty ? '0 : head;
  // illegal-channel responses complete the handshake but are never written
  mcash_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push && ch_ok),
    .pop(bus.sc_xbar_valid_o && bus.sc_xbar_allowIn_i),
    .din({bus.rsp_ch_id_i, bus.rsp_rob_num_i, bus.rsp_data_i}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(occupancy_o)
  );
  always_ff @(posedge clk_i)
    ch_err_o <= rst_i ? 1'b0 : push && !ch_ok;
endmodule

// File: tb/tb_bank_sc_rtn_tx.sv
// tb_bank_sc_rtn_tx: table vectors, hand sequences and random traffic checked against a queue model
module tb_bank_sc_rtn_tx;
  import mcash_xbar_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [2:0] occ;
  logic ch_err;
  int checks = 0;
  int failures = 0;
  rtn_pkt_t mq[$];
  logic m_err = 1'b0;
  logic d_r, d_v, d_a, e_v, e_rdy;
  logic [1:0] d_ch;
  logic [2:0] d_rob;
  logic [127:0] d_data;
  bank_sc_rtn_tx_if bus ();
  bank_sc_rtn_tx #(.DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus(bus),
    .occupancy_o(occ),
    .ch_err_o(ch_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, v;
    logic [1:0] ch;
    logic [2:0] rob;
    logic [127:0] d;
    logic a;
    logic ev, er;
    logic [2:0] eo;
    logic ee;
    logic [1:0] ech;
    logic [2:0] erob;
    logic [127:0] ed;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic drive(input logic r, v, input logic [1:0] ch, input logic [2:0] rob,
                       input logic [127:0] d, input logic a);
    @(negedge clk);
    d_r = r; d_v = v; d_ch = ch; d_rob = rob; d_data = d; d_a = a;
    rst_i = r;
    bus.rsp_valid_i = v;
    bus.rsp_ch_id_i = ch;
    bus.rsp_rob_num_i = rob;
    bus.rsp_data_i = d;
    bus.sc_xbar_allowIn_i = a;
    #1;
    e_v = mq.size() != 0;
    e_rdy = !r && mq.size() < DEPTH;
    chk("m_valid", bus.sc_xbar_valid_o, e_v);
    chk("m_ready", bus.rsp_ready_o, e_rdy);
    chk("m_occ", occ, mq.size());
    chk("m_err", ch_err, m_err);
    chk("m_ch", bus.sc_xbar_ch_id_o, e_v ? mq[0].ch_id : 2'd0);
    chk("m_rob", bus.sc_xbar_rob_num_o, e_v ? mq[0].rob_num : 3'd0);
    chk("m_data", bus.sc_xbar_data_o, e_v ? mq[0].data : 128'd0);
  endtask
  task automatic tick();
    logic pushed;
    @(posedge clk);
    if (d_r) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      pushed = d_v && e_rdy;
      if (e_v && d_a) void'(mq.pop_front());
      if (pushed && d_ch != CH_ID_ILLEGAL) mq.push_back('{d_ch, d_rob, d_data});
      m_err = pushed && d_ch == CH_ID_ILLEGAL;
    end
  endtask
  task automatic step(input logic r, v, input logic [1:0] ch, input logic [2:0] rob,
                      input logic [127:0] d, input logic a);
    drive(r, v, ch, rob, d, a);
    tick();
  endtask
  initial begin
    logic [127:0] a5, ff;
    a5 = {16{8'hA5}};
    ff = {16{8'hFF}};
    bus.rsp_valid_i = 1'b0;
    bus.rsp_ch_id_i = '0;
    bus.rsp_rob_num_i = '0;
    bus.rsp_data_i = '0;
    bus.sc_xbar_allowIn_i = 1'b0;
    vecs[0] = '{1'b1, 1'b0, 2'd0, 3'd0, 128'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 3'd0, 128'd0};
    vecs[1] = '{1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 3'd0, 128'd0};
    vecs[2] = '{1'b0, 1'b1, 2'd1, 3'd5, a5, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 3'd0, 128'd0};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 2'd1, 3'd5, a5};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 3'd0, 128'd0};
    vecs[5] = '{1'b0, 1'b1, 2'd3, 3'd2, ff, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 3'd0, 128'd0};
    vecs[6] = '{1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 2'd0, 3'd0, 128'd0};
    vecs[7] = '{1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 3'd0, 128'd0};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].ch, vecs[i].rob, vecs[i].d, vecs[i].a);
      chk($sformatf("v%0d_valid", i), bus.sc_xbar_valid_o, vecs[i].ev);
      chk($sformatf("v%0d_ready", i), bus.rsp_ready_o, vecs[i].er);
      chk($sformatf("v%0d_occ", i), occ, vecs[i].eo);
      chk($sformatf("v%0d_err", i), ch_err, vecs[i].ee);
      chk($sformatf("v%0d_ch", i), bus.sc_xbar_ch_id_o, vecs[i].ech);
      chk($sformatf("v%0d_rob", i), bus.sc_xbar_rob_num_o, vecs[i].erob);
      chk($sformatf("v%0d_data", i), bus.sc_xbar_data_o, vecs[i].ed);
      tick();
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd0, 3'(i), 128'(i + 100), 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 2'd2, 3'd7, ff, 1'b0);
      chk("full_occ", occ, 3'd4);
      chk("full_ready", bus.rsp_ready_o, 1'b0);
      chk("hold_rob", bus.sc_xbar_rob_num_o, 3'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1);
      chk("drain_rob", bus.sc_xbar_rob_num_o, 3'(i));
      chk("drain_valid", bus.sc_xbar_valid_o, 1'b1);
      tick();
    end
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i % 3), 3'(i + round), 128'($urandom), 1'b0);
      drive(1'b0, 1'b1, 2'd1, 3'd6, a5, 1'b1);
      chk("popfull_ready", bus.rsp_ready_o, 1'b0);
      tick();
      drive(1'b0, 1'b1, 2'd1, 3'd6, a5, 1'b1);
      chk("popfull_ready_next", bus.rsp_ready_o, 1'b1);
      chk("popfull_occ", occ, 3'd3);
      tick();
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1);
      drive(1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1);
      chk("round_empty", occ, 3'd0);
      tick();
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd2, 3'(i), ff, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1);
    chk("rst_ready", bus.rsp_ready_o, 1'b0);
    chk("rst_occ_before_edge", occ, 3'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'd0, 3'd0, 128'd0, 1'b1);
      chk("post_rst_valid", bus.sc_xbar_valid_o, 1'b0);
      chk("post_rst_occ", occ, 3'd0);
      chk("post_rst_ready", bus.rsp_ready_o, 1'b1);
      tick();
    end
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
           3'($urandom), {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
